// File: rtl/datapath.sv
// Datapath slice: R0, R1 and MDR share one WIDTH-bit bus picked by a priority-encoded one-hot select.
// Latency: bus is combinational (0 cycles); register loads appear 1 cycle after the enabling edge.
// Backpressure: none; enables are obeyed on every edge and Clear overrides them all.
// Optional feature: define DATAPATH_MEM_BYPASS_EN to make encIn[3] drive Mdatain straight onto the bus.
module datapath #(
  parameter int WIDTH = 32
) (
  input  logic             Clock,
  input  logic             Clear,
  input  logic [WIDTH-1:0] Mdatain,
  input  logic [31:0]      encIn,
  input  logic             Read,
  input  logic             R0in,
  input  logic             R1in,
  input  logic             MDRin,
  output logic [WIDTH-1:0] busMuxOut,
  output logic [WIDTH-1:0] R0out,
  output logic [WIDTH-1:0] R1out,
  output logic [WIDTH-1:0] MDRout
);

  // Source indices produced by the encoder; anything else is a reserved source.
  localparam logic [4:0] SRC_R0  = 5'd0;
  localparam logic [4:0] SRC_R1  = 5'd1;
  localparam logic [4:0] SRC_MDR = 5'd2;
`ifdef DATAPATH_MEM_BYPASS_EN
  localparam logic [4:0] SRC_MEM = 5'd3;
`endif

  logic [4:0]       enc_idx;
  logic             enc_vld;
  logic [WIDTH-1:0] r0_d,  r0_q;
  logic [WIDTH-1:0] r1_d,  r1_q;
  logic [WIDTH-1:0] mdr_d, mdr_q;

  // Priority encoder: scan from the top so the lowest set bit is the last to write.
  always_comb begin
    enc_idx = '0;
    enc_vld = 1'b0;
    for (int i = 31; i >= 0; i--) begin
      if (encIn[i]) begin
        enc_idx = 5'(i);
        enc_vld = 1'b1;
      end
    end
  end

  // Bus mux: reserved or absent selects leave the bus at zero rather than floating.
  always_comb begin
    busMuxOut = '0;
    if (enc_vld) begin
      case (enc_idx)
        SRC_R0:  busMuxOut = r0_q;
        SRC_R1:  busMuxOut = r1_q;
        SRC_MDR: busMuxOut = mdr_q;
`ifdef DATAPATH_MEM_BYPASS_EN
        SRC_MEM: busMuxOut = Mdatain;
`endif
        default: busMuxOut = '0;
      endcase
    end
  end

  // Next-state for the register file: enabled registers take the pre-edge bus, MDR may take memory.
  always_comb begin
    r0_d  = r0_q;
    r1_d  = r1_q;
    mdr_d = mdr_q;
    if (R0in)  r0_d  = busMuxOut;
    if (R1in)  r1_d  = busMuxOut;
    if (MDRin) mdr_d = Read ? Mdatain : busMuxOut;
  end

  // State registers with synchronous clear taking precedence over every load enable.
  always_ff @(posedge Clock) begin
    if (Clear) begin
      r0_q  <= '0;
      r1_q  <= '0;
      mdr_q <= '0;
    end else begin
      r0_q  <= r0_d;
      r1_q  <= r1_d;
      mdr_q <= mdr_d;
    end
  end

  assign R0out  = r0_q;
  assign R1out  = r1_q;
  assign MDRout = mdr_q;

endmodule

// File: tb/tb_datapath.sv
// Bench for datapath: directed steps from the block's test list followed by random traffic.
// Expected values come from a register-level model that applies the load rules each edge.
module tb_datapath;

  logic        Clock = 1'b0;
  logic        Clear = 1'b0;
  logic [31:0] Mdatain = '0;
  logic [31:0] encIn = '0;
  logic        Read = 1'b0;
  logic        R0in = 1'b0;
  logic        R1in = 1'b0;
  logic        MDRin = 1'b0;
  logic [31:0] busMuxOut, R0out, R1out, MDRout;

  int passed = 0;
  int total  = 0;

  // Reference state
  logic [31:0] m_r0, m_r1, m_mdr;
  bit          m_known = 1'b0;

  datapath #(.WIDTH(32)) dut (
    .Clock    (Clock),
    .Clear    (Clear),
    .Mdatain  (Mdatain),
    .encIn    (encIn),
    .Read     (Read),
    .R0in     (R0in),
    .R1in     (R1in),
    .MDRin    (MDRin),
    .busMuxOut(busMuxOut),
    .R0out    (R0out),
    .R1out    (R1out),
    .MDRout   (MDRout)
  );

  always #5 Clock = ~Clock;

  // Bus seen by the model: isolate the lowest set bit arithmetically and map it to a source.
  function automatic logic [31:0] ref_bus(input logic [31:0] enc, input logic [31:0] md);
    logic [31:0] low;
    low = enc & (~enc + 32'd1);
    if (low == 32'd1) return m_r0;
    if (low == 32'd2) return m_r1;
    if (low == 32'd4) return m_mdr;
`ifdef DATAPATH_MEM_BYPASS_EN
    if (low == 32'd8) return md;
`endif
    return 32'd0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // One clock step: drive at negedge, check the combinational bus, clock, update model, check state.
  task automatic step(input string tag, input logic clr, input logic [31:0] md, input logic [31:0] enc,
                      input logic rd, input logic r0i, input logic r1i, input logic mdri);
    logic [31:0] b;
    Clear = clr; Mdatain = md; encIn = enc; Read = rd; R0in = r0i; R1in = r1i; MDRin = mdri;
    #1;
    if (m_known) chk({tag, "_bus_pre"}, busMuxOut, ref_bus(enc, md));
    b = ref_bus(enc, md);
    @(posedge Clock);
    if (clr) begin
      m_r0 = '0; m_r1 = '0; m_mdr = '0;
      m_known = 1'b1;
    end else begin
      if (r0i)  m_r0  = b;
      if (r1i)  m_r1  = b;
      if (mdri) m_mdr = rd ? md : b;
    end
    @(negedge Clock);
    chk({tag, "_r0"},  R0out,  m_r0);
    chk({tag, "_r1"},  R1out,  m_r1);
    chk({tag, "_mdr"}, MDRout, m_mdr);
    chk({tag, "_bus"}, busMuxOut, ref_bus(encIn, Mdatain));
  endtask

  initial begin
    logic [31:0] enc_r;
    logic [31:0] md_r;
    logic [31:0] byp_exp;
    int          sel;

    @(negedge Clock);

    // Reset with every enable high and memory all ones
    step("reset", 1'b1, 32'hFFFF_FFFF, 32'h1, 1'b1, 1'b1, 1'b1, 1'b1);
    chk("reset_r0_zero", R0out, 32'h0);
    chk("reset_bus_zero", busMuxOut, 32'h0);

    // MDR loads from memory, then holds over three edges
    step("mdr_load", 1'b0, 32'h12, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("mdr_is_12", MDRout, 32'h12);
    for (int i = 0; i < 3; i++)
      step("mdr_hold", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("mdr_still_12", MDRout, 32'h12);

    // MDR onto bus without a clock, then into R0
    Clear = 1'b0; encIn = 32'h4; R0in = 1'b0; MDRin = 1'b0;
    #1;
    chk("bus_mdr_noclk", busMuxOut, 32'h12);
    step("r0_from_mdr", 1'b0, 32'h0, 32'h4, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("r0_is_12", R0out, 32'h12);
    chk("r1_unchanged", R1out, 32'h0);

    // R0 into R1, then priority and empty select
    step("r1_from_r0", 1'b0, 32'h0, 32'h1, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("r1_is_12", R1out, 32'h12);
    step("prio_r0", 1'b0, 32'h0, 32'h3, 1'b0, 1'b0, 1'b0, 1'b0);
    step("enc_zero", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("enc_zero_bus", busMuxOut, 32'h0);

    // Reserved high bits only
    step("reserved", 1'b0, 32'h5, 32'hF000_0010, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("reserved_bus", busMuxOut, 32'h0);

    // Change R1 so the fan-out below is visible, then load all three from R0
    step("r1_from_mdr_mem", 1'b0, 32'h77, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);
    step("r1_ld", 1'b0, 32'h0, 32'h4, 1'b0, 1'b0, 1'b1, 1'b0);
    step("fanout", 1'b0, 32'h0, 32'h1, 1'b0, 1'b1, 1'b1, 1'b1);
    chk("fanout_r0", R0out, 32'h12);
    chk("fanout_r1", R1out, 32'h12);
    chk("fanout_mdr", MDRout, 32'h12);

    // Loop-back holds R0
    step("loopback", 1'b0, 32'h0, 32'h1, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("loopback_r0", R0out, 32'h12);

    // Same fan-out with Clear asserted
    step("fanout_clr", 1'b1, 32'h0, 32'h1, 1'b0, 1'b1, 1'b1, 1'b1);
    chk("clr_r0", R0out, 32'h0);
    chk("clr_r1", R1out, 32'h0);
    chk("clr_mdr", MDRout, 32'h0);

    // Enables resume on the first edge after Clear drops
    step("post_clr", 1'b0, 32'h3C, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("post_clr_mdr", MDRout, 32'h3C);

    // Memory bypass select
`ifdef DATAPATH_MEM_BYPASS_EN
    byp_exp = 32'hA5A5_A5A5;
`else
    byp_exp = 32'h0;
`endif
    Mdatain = 32'hA5A5_A5A5; encIn = 32'h8; R0in = 1'b0; R1in = 1'b0; MDRin = 1'b0;
    #1;
    chk("bypass_bus", busMuxOut, byp_exp);
    step("bypass_r1", 1'b0, 32'hA5A5_A5A5, 32'h8, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("bypass_r1_val", R1out, byp_exp);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      sel = $urandom_range(0, 9);
      case (sel)
        0: enc_r = 32'h1;
        1: enc_r = 32'h2;
        2: enc_r = 32'h4;
        3: enc_r = 32'h8;
        4: enc_r = 32'h0;
        5: enc_r = $urandom() & 32'hFFFF_FFF0;
        6: enc_r = $urandom() | 32'h1;
        default: enc_r = $urandom();
      endcase
      md_r = $urandom();
      step("rand", ($urandom_range(0, 19) == 0), md_r, enc_r, 1'($urandom()),
           1'($urandom()), 1'($urandom()), 1'($urandom()));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
